// File: rtl/edge_window_scheduler_if.sv
// Pixel-in / window-out stream bundle for the edge window scheduler.
// slave = scheduler side, master = pixel source and window sink.
interface edge_window_scheduler_if;
    logic [7:0]   pix_in;
    logic         pix_valid;
    logic         pix_ready;
    logic [199:0] win_out;
    logic         win_valid;
    logic         win_ready;

    modport slave (
        input  pix_in,
        input  pix_valid,
        input  win_ready,
        output pix_ready,
        output win_out,
        output win_valid
    );

    modport master (
        output pix_in,
        output pix_valid,
        output win_ready,
        input  pix_ready,
        input  win_out,
        input  win_valid
    );
endinterface

// File: rtl/edge_window_scheduler.sv
// 5x5 raster window scheduler: 4 line buffers plus a shifting window.
// Optional EDGE_WINDOW_STALL_CNT_EN adds a per-frame stall_cnt output.
module edge_window_scheduler #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] mode,
    edge_window_scheduler_if.slave bus,
    output logic [1:0] filt_sel,
    output logic       busy,
    output logic       done
`ifdef EDGE_WINDOW_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_FILL = CW'(4);
    localparam logic [RW-1:0] ROW_FILL = RW'(4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_FLUSH
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;

    // r_lb[0] is the oldest line (row-4), r_lb[3] the newest (row-1)
    logic [7:0] r_lb [4][IMG_WIDTH];
    logic [7:0] r_win [5][5];

    logic       r_wvld;
    logic       r_done;
    logic [1:0] r_fsel;

    logic         w_pix_ready;
    logic         w_pix_acc;
    logic         w_win_xfer;
    logic         w_last_pix;
    logic         w_col_wrap;
    logic         w_emit;
    logic         w_start_acc;
    logic         w_flush_end;
    logic [7:0]   w_col_new [5];
    logic [199:0] w_win_pack;

    // Handshake qualifiers
    always_comb begin
        w_pix_ready = (r_state == S_ACTIVE)
                    && (!r_wvld || bus.win_ready);
        w_pix_acc   = bus.pix_valid && w_pix_ready;
        w_win_xfer  = r_wvld && bus.win_ready;
        w_col_wrap  = (r_col == COL_LAST);
        w_last_pix  = (r_row == ROW_LAST) && w_col_wrap;
        w_emit      = w_pix_acc
                    && (r_row >= ROW_FILL)
                    && (r_col >= COL_FILL);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and strobes
    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        w_flush_end = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (w_pix_acc && w_last_pix) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // Leaves once the final window is taken
                if (!r_wvld || bus.win_ready) begin
                    w_flush_end = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Raster position of the next pixel to accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_start_acc) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_pix_acc) begin
            if (w_col_wrap) begin
                r_col <= '0;
                if (w_last_pix) begin
                    r_row <= '0;
                end else begin
                    r_row <= r_row + RW'(1);
                end
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // New window column: four buffered lines above plus the live pixel
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_col_new[k] = r_lb[k][r_col];
        end
        w_col_new[4] = bus.pix_in;
    end

    // Line buffers; stale contents are masked by the window fill rule
    always_ff @(posedge clk) begin
        if (w_pix_acc) begin
            for (int k = 0; k < 3; k++) begin
                r_lb[k][r_col] <= r_lb[k+1][r_col];
            end
            r_lb[3][r_col] <= bus.pix_in;
        end
    end

    // 5x5 window shifts left one column per accepted pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 5; c++) begin
                    r_win[r][c] <= 8'h00;
                end
            end
        end else if (w_pix_acc) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 4; c++) begin
                    r_win[r][c] <= r_win[r][c+1];
                end
                r_win[r][4] <= w_col_new[r];
            end
        end
    end

    // Row r at [40r+39:40r], column c at [40r+8c+7:40r+8c]
    always_comb begin
        w_win_pack = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                w_win_pack[40*r+8*c +: 8] = r_win[r][c];
            end
        end
    end

    // Window valid: set by a filling pixel, cleared on transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wvld <= 1'b0;
        end else if (w_emit) begin
            r_wvld <= 1'b1;
        end else if (w_win_xfer) begin
            r_wvld <= 1'b0;
        end
    end

    // Filter select latched on accepted start; reserved mode maps to x
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsel <= 2'd0;
        end else if (w_start_acc) begin
            r_fsel <= (mode == 2'd3) ? 2'd0 : mode;
        end
    end

    // Frame completion pulse, one cycle after the last window leaves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_flush_end;
        end
    end

`ifdef EDGE_WINDOW_STALL_CNT_EN
    logic [15:0] r_stall;

    // Saturating count of back-pressured window cycles this frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= 16'h0000;
        end else if (w_start_acc) begin
            r_stall <= 16'h0000;
        end else if (r_wvld && !bus.win_ready
                     && (r_stall != 16'hFFFF)) begin
            r_stall <= r_stall + 16'h0001;
        end
    end

    assign stall_cnt = r_stall;
`endif

    assign bus.pix_ready = w_pix_ready;
    assign bus.win_out   = w_win_pack;
    assign bus.win_valid = r_wvld;
    assign filt_sel      = r_fsel;
    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;

endmodule

// File: tb/tb_edge_window_scheduler.sv
// Scoreboard bench for edge_window_scheduler on an 8x8 frame.
// Feeder pushes expected windows; a negedge monitor pops on transfer.
module tb_edge_window_scheduler;

    localparam int W = 8;
    localparam int H = 8;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] mode;
    logic [1:0] filt_sel;
    logic       busy;
    logic       done;
`ifdef EDGE_WINDOW_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    edge_window_scheduler_if ewif ();

    edge_window_scheduler #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .mode    (mode),
        .bus     (ewif.slave),
        .filt_sel(filt_sel),
        .busy    (busy),
        .done    (done)
`ifdef EDGE_WINDOW_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    int n_vec  = 0;
    int n_err  = 0;
    int n_win  = 0;
    int n_done = 0;

    logic [199:0] exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [199:0] act,
                       input logic [199:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endtask

    function automatic logic [7:0] pval(input int seed,
                                        input int r,
                                        input int c);
        int v;
        v = seed + r * W + c;
        return v[7:0];
    endfunction

    function automatic logic [199:0] expwin(input int seed,
                                            input int wr,
                                            input int wc);
        logic [199:0] w;
        w = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                w[40*r+8*c +: 8] = pval(seed, wr - 4 + r, wc - 4 + c);
            end
        end
        return w;
    endfunction

    // Monitor: compare every transferred window, count done pulses
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                n_done++;
                chk("busy_at_done", {199'd0, busy}, 200'd0);
            end
            if (ewif.win_valid && ewif.win_ready) begin
                n_win++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL window_unexpected: got %0h expected none",
                             ewif.win_out);
                end else begin
                    chk("window", ewif.win_out, exp_q.pop_front());
                end
            end
        end
    end

    // Feed npix raster pixels, pushing each expected window on acceptance
    task automatic send_frame(input int seed,
                              input int npix,
                              input bit gaps);
        int idx;
        int guard;
        int r;
        int c;
        idx = 0;
        guard = 0;
        while (idx < npix && guard < 5000) begin
            @(posedge clk);
            #1;
            r = idx / W;
            c = idx % W;
            if (gaps && $urandom_range(0, 2) == 0) begin
                ewif.pix_valid = 1'b0;
                ewif.pix_in = 8'hEE;
            end else begin
                ewif.pix_valid = 1'b1;
                ewif.pix_in = pval(seed, r, c);
            end
            @(negedge clk);
            if (ewif.pix_valid && ewif.pix_ready) begin
                if (r >= 4 && c >= 4) begin
                    exp_q.push_back(expwin(seed, r, c));
                end
                idx++;
            end
            guard++;
        end
        @(posedge clk);
        #1;
        ewif.pix_valid = 1'b0;
        chk("pixels_sent", 200'(idx), 200'(npix));
    endtask

    // Hold off the first window for five cycles and check it is frozen
    task automatic stall_first();
        logic [199:0] cap;
        int g;
        g = 0;
        @(negedge clk);
        while (!ewif.win_valid && g < 1000) begin
            @(negedge clk);
            g++;
        end
        chk("first_win_seen", {199'd0, ewif.win_valid}, 200'd1);
        cap = ewif.win_out;
        chk("first_row0", {160'd0, cap[39:0]},
            {160'd0, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0});
        chk("first_row4", {160'd0, cap[199:160]},
            {160'd0, 8'd36, 8'd35, 8'd34, 8'd33, 8'd32});
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("stall_win_stable", ewif.win_out, cap);
            chk("stall_valid", {199'd0, ewif.win_valid}, 200'd1);
            chk("stall_pix_ready", {199'd0, ewif.pix_ready}, 200'd0);
        end
        @(posedge clk);
        #1;
        ewif.win_ready = 1'b1;
    endtask

    // Random window back-pressure until the frame completes
    task automatic rand_ready();
        for (int g = 0; g < 3000; g++) begin
            @(posedge clk);
            #1;
            ewif.win_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (done) break;
        end
        ewif.win_ready = 1'b1;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 1000; i++) begin
            if (n_done >= target) break;
            @(negedge clk);
            #1;
        end
        chk("done_count", 200'(n_done), 200'(target));
    endtask

    task automatic start_frame(input logic [1:0] m);
        @(posedge clk);
        #1;
        start = 1'b1;
        mode = m;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        mode = 2'd0;
        ewif.pix_in = 8'h00;
        ewif.pix_valid = 1'b0;
        ewif.win_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pix_ready", {199'd0, ewif.pix_ready}, 200'd0);
        chk("rst_win_valid", {199'd0, ewif.win_valid}, 200'd0);
        chk("rst_win_out", ewif.win_out, 200'd0);
        chk("rst_filt_sel", {198'd0, filt_sel}, 200'd0);
        chk("rst_busy", {199'd0, busy}, 200'd0);
        chk("rst_done", {199'd0, done}, 200'd0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ewif.pix_valid = 1'b1;
        ewif.pix_in = 8'h55;
        @(negedge clk);
        chk("idle_pix_ready", {199'd0, ewif.pix_ready}, 200'd0);

        // Frame 1: ramp, mode 2, second start ignored, first window stalled
        n_win = 0;
        ewif.win_ready = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1;
        mode = 2'd2;
        ewif.pix_in = 8'hAA;
        @(negedge clk);
        chk("start_pix_blocked", {199'd0, ewif.pix_ready}, 200'd0);
        @(posedge clk);
        #1;
        start = 1'b1;
        mode = 2'd1;
        ewif.pix_valid = 1'b0;
        @(negedge clk);
        chk("busy_after_start", {199'd0, busy}, 200'd1);
        chk("filt_sel_latched", {198'd0, filt_sel}, 200'd2);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("filt_sel_hold", {198'd0, filt_sel}, 200'd2);
        fork
            send_frame(0, W * H, 1'b0);
            stall_first();
        join
        wait_done(1);
        chk("f1_filt_sel_end", {198'd0, filt_sel}, 200'd2);
        chk("f1_windows", 200'(n_win), 200'd16);
        chk("f1_queue_empty", 200'(exp_q.size()), 200'd0);
`ifdef EDGE_WINDOW_STALL_CNT_EN
        chk("f1_stall_cnt", {184'd0, stall_cnt}, 200'd5);
`endif
        repeat (3) @(negedge clk);
        chk("f1_done_once", 200'(n_done), 200'd1);
        chk("f1_idle_busy", {199'd0, busy}, 200'd0);

        // Frame 2: aborted by reset after 20 pixels
        ewif.win_ready = 1'b1;
        start_frame(2'd1);
        send_frame(50, 20, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", {199'd0, busy}, 200'd0);
        chk("midrst_pix_ready", {199'd0, ewif.pix_ready}, 200'd0);
        chk("midrst_win_out", ewif.win_out, 200'd0);
        chk("midrst_filt_sel", {198'd0, filt_sel}, 200'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Frame 3: full frame after reset, no stale data
        n_win = 0;
        start_frame(2'd1);
        chk("f3_filt_sel", {198'd0, filt_sel}, 200'd1);
        send_frame(77, W * H, 1'b0);
        wait_done(2);
        chk("f3_windows", 200'(n_win), 200'd16);
        chk("f3_queue_empty", 200'(exp_q.size()), 200'd0);

        // Frame 4: reserved mode, random pixel and window gaps
        n_win = 0;
        start_frame(2'd3);
        chk("f4_filt_sel", {198'd0, filt_sel}, 200'd0);
        fork
            send_frame(150, W * H, 1'b1);
            rand_ready();
        join
        wait_done(3);
        chk("f4_windows", 200'(n_win), 200'd16);
        chk("f4_queue_empty", 200'(exp_q.size()), 200'd0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/edge_window_scheduler.md
EDGE_WINDOW_SCHEDULER -- requirements
Module: edge_window_scheduler

Interface
REQ-001 Parameter IMG_WIDTH, default 64, pixels per line; legal range 5..1024.
REQ-002 Parameter IMG_HEIGHT, default 64, lines per frame; legal range 5..1024.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle frame start request; honoured only in IDLE.
REQ-006 mode  input  2  filter select sampled at start: 0=x, 1=y, 2=log, 3=reserved (treated as 0).
REQ-007 pix_in  input  8  raster-order input pixel.
REQ-008 pix_valid  input  1  pix_in valid.
REQ-009 pix_ready  output  1  block accepts pix_in this cycle.
REQ-010 win_out  output  200  5x5 window for the filter datapath.
REQ-011 win_valid  output  1  win_out valid.
REQ-012 win_ready  input  1  downstream accepts win_out.
REQ-013 filt_sel  output  2  latched filter select driven to the datapath mux.
REQ-014 busy  output  1  high from start acceptance until done.
REQ-015 done  output  1  one-cycle pulse at frame completion.

Function
REQ-016 States: IDLE, ACTIVE, FLUSH; IDLE->ACTIVE on start; ACTIVE->FLUSH on acceptance of pixel (IMG_HEIGHT-1, IMG_WIDTH-1); FLUSH->IDLE when no window is pending.
REQ-017 Pixel handshake: transfer when pix_valid && pix_ready; pix_ready = ACTIVE && (!win_valid || win_ready).
REQ-018 Window handshake: transfer when win_valid && win_ready; win_out, win_valid held stable while win_valid && !win_ready.
REQ-019 Four line buffers of IMG_WIDTH x 8 bits hold the previous four lines; a 5x5 register window shifts left one column per accepted pixel.
REQ-020 Packing: row r (0 = oldest line) occupies bits [40r+39:40r]; column c (0 = leftmost) occupies [40r+8c+7:40r+8c].
REQ-021 Column counter wraps IMG_WIDTH-1 -> 0 and increments the row counter; no window spans a line wrap.
REQ-022 A window is emitted only when the accepted pixel has row >= 4 and col >= 4; win_valid rises the cycle after that acceptance (latency 1).
REQ-023 Windows per frame = (IMG_WIDTH-4) x (IMG_HEIGHT-4); border pixels produce no window.
REQ-024 done pulses the cycle after the final window transfer; busy falls in the same cycle.
REQ-025 start while busy is ignored; start and pixel valid in the same IDLE cycle: pixel not accepted that cycle.
REQ-026 filt_sel updates only on accepted start; mode 3 maps to 0.
REQ-027 Pixels presented in IDLE or FLUSH are not accepted (pix_ready low).

Reset
REQ-028 rst_n low immediately forces IDLE, counters 0, win_valid 0, win_out 0, filt_sel 0, busy 0, done 0, pix_ready 0.
REQ-029 Reset mid-frame discards the partial frame; line-buffer contents need not be cleared, as the fill rule (REQ-022) masks stale data.
REQ-030 Deassertion is used only after synchronisation by the system; the block does not resynchronise it.

Configuration
REQ-031 Macro EDGE_WINDOW_STALL_CNT_EN defined: adds output stall_cnt (16 bits), counting cycles with win_valid && !win_ready in the current frame, saturating at 0xFFFF, cleared on accepted start and reset.
REQ-032 Macro undefined: no stall_cnt port and no counter logic; all other behaviour is identical.

Verification (IMG_WIDTH=8, IMG_HEIGHT=8)
REQ-033 Frame pixel value = row*8+col, win_ready=1 -> exactly 16 windows; the first window's row0 bytes are 0,1,2,3,4 and its row4 bytes are 32..36; done pulses once.
REQ-034 Hold win_ready=0 for 5 cycles at the first window -> win_out stable, pix_ready=0, and no pixel is lost.
REQ-035 start with mode=2, then start with mode=1 while busy -> filt_sel stays 2 for the whole frame.
REQ-036 rst_n low after 20 pixels, then a new frame -> 16 correct windows with no stale data.
REQ-037 Random pix_valid and win_ready gaps -> window sequence matches the gap-free reference, and the window count is 16.
REQ-038 With EDGE_WINDOW_STALL_CNT_EN, 5 stall cycles inserted -> stall_cnt = 5 at done.
